// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer
// Parallel-to-serial front end for the bit-serial arithmetic datapath.
// Latches two WIDTH-bit operands plus a carry-in on a valid/ready accept and
// drives them out LSB-first, one bit per clock, with framing strobes.
// Optional build macro SER_SUB_EN: adds in_sub, which sends ~in_b and forces
// the frame carry-in to 1 (two's-complement subtract feed).
module serial_operand_serializer #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             a_out,
    output logic             b_out,
    output logic             cin_out,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy,
    output logic [CNT_W-1:0] bit_idx,
    output logic             done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic             a_out_q, b_out_q, cin_out_q;
    logic             frame_start_q, frame_last_q, busy_q, done_q;
    logic [CNT_W-1:0] bit_idx_q;

    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef SER_SUB_EN
    assign b_load   = in_sub ? ~in_b : in_b;
    assign cin_load = in_sub | in_cin;
`else
    assign b_load   = in_b;
    assign cin_load = in_cin;
`endif

    // frame_last_q marks the last bit, the only SHIFT cycle that can take a new set
    assign in_ready = !rst && ((state_q == IDLE) || frame_last_q);
    assign accept   = in_valid && in_ready;

    // Frame FSM; every serial and framing output is a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            a_out_q       <= 1'b0;
            b_out_q       <= 1'b0;
            cin_out_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            busy_q        <= 1'b0;
            bit_idx_q     <= '0;
            done_q        <= 1'b0;
        end else if (accept) begin
            // bit 0 goes straight to the outputs, the rest waits in the shifters
            state_q       <= SHIFT;
            a_sh_q        <= in_a >> 1;
            b_sh_q        <= b_load >> 1;
            a_out_q       <= in_a[0];
            b_out_q       <= b_load[0];
            cin_out_q     <= cin_load;
            frame_start_q <= 1'b1;
            frame_last_q  <= 1'b0;
            busy_q        <= 1'b1;
            bit_idx_q     <= '0;
            // back-to-back accept still closes the previous frame
            done_q        <= (state_q == SHIFT);
        end else if (state_q == SHIFT && !frame_last_q) begin
            a_out_q       <= a_sh_q[0];
            b_out_q       <= b_sh_q[0];
            a_sh_q        <= a_sh_q >> 1;
            b_sh_q        <= b_sh_q >> 1;
            bit_idx_q     <= bit_idx_q + CNT_W'(1);
            frame_start_q <= 1'b0;
            frame_last_q  <= (bit_idx_q == CNT_W'(WIDTH - 2));
            done_q        <= 1'b0;
        end else if (state_q == SHIFT) begin
            // last bit with nothing queued behind it
            state_q       <= IDLE;
            a_out_q       <= 1'b0;
            b_out_q       <= 1'b0;
            cin_out_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            busy_q        <= 1'b0;
            bit_idx_q     <= '0;
            done_q        <= 1'b1;
        end else begin
            done_q        <= 1'b0;
        end
    end

    assign a_out       = a_out_q;
    assign b_out       = b_out_q;
    assign cin_out     = cin_out_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
    assign busy        = busy_q;
    assign bit_idx     = bit_idx_q;
    assign done        = done_q;

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer (WIDTH=4). A queue model expands every
// accepted operand set into its per-cycle bit schedule; a negedge process
// compares the DUT against it each cycle, and directed tests add literal checks.
module tb_serial_operand_serializer;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic          in_cin;
    logic          sub_i;
    logic          a_out, b_out, cin_out, frame_start, frame_last, busy, done;
    logic [CW-1:0] bit_idx;

    int nvec = 0;
    int nerr = 0;

    serial_operand_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SER_SUB_EN
        .in_sub(sub_i),
`endif
        .a_out(a_out), .b_out(b_out), .cin_out(cin_out),
        .frame_start(frame_start), .frame_last(frame_last),
        .busy(busy), .bit_idx(bit_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: one queue entry per upcoming bit-cycle ----------
    typedef struct {
        logic a, b, cin, fs, fl;
        int   idx;
    } bit_t;

    bit_t q[$];
    logic m_done = 1'b0;
    int   m_acc  = 0;
    int   dut_acc = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) begin
        logic was_last, acc, bb, cc;
        bit_t e;
        if (rst) begin
            q.delete();
            m_done = 1'b0;
        end else begin
            acc      = in_valid && (q.size() <= 1);
            was_last = (q.size() > 0) && q[0].fl;
            if (q.size() > 0) void'(q.pop_front());
            m_done = was_last;
            if (acc) begin
                m_acc++;
                for (int i = 0; i < W; i++) begin
                    bb = in_b[i];
                    cc = in_cin;
`ifdef SER_SUB_EN
                    if (sub_i) begin bb = ~bb; cc = 1'b1; end
`endif
                    e.a = in_a[i]; e.b = bb; e.cin = cc;
                    e.fs = (i == 0); e.fl = (i == W - 1); e.idx = i;
                    q.push_back(e);
                end
            end
        end
    end

    // per-cycle compare of every output against the model
    always @(negedge clk) begin
        logic [9:0] act, exp;
        logic       er;
        if (chk_en) begin
            er = !rst && (q.size() <= 1);
            if (q.size() > 0)
                exp = {er, q[0].a, q[0].b, q[0].cin, q[0].fs, q[0].fl, 1'b1, CW'(q[0].idx), m_done};
            else
                exp = {er, 6'b0, CW'(0), m_done};
            act = {in_ready, a_out, b_out, cin_out, frame_start, frame_last, busy, bit_idx, done};
            chk("cycle", 32'(act), 32'(exp));
            if (in_valid && in_ready) dut_acc++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        in_valid = v; in_a = a; in_b = b; in_cin = c; sub_i = s;
    endtask

    task automatic collect(output logic [W-1:0] ca, output logic [W-1:0] cb,
                           output logic [W-1:0] cc, output logic [W-1:0] cs,
                           output logic [W-1:0] cl);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            ca[i] = a_out; cb[i] = b_out; cc[i] = cin_out;
            cs[i] = frame_start; cl[i] = frame_last;
        end
    endtask

    initial begin
        logic [W-1:0] ca, cb, cc, cs, cl;
        int acc0, dacc0;
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_outs", 32'({a_out, b_out, cin_out, frame_start, frame_last, busy, bit_idx, done}), 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // single frame
        @(posedge clk); #1 drive(1'b1, 4'b1011, 4'b0110, 1'b0, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        collect(ca, cb, cc, cs, cl);
        chk("t1_a", 32'(ca), 32'h0000000B);
        chk("t1_b", 32'(cb), 32'h00000006);
        chk("t1_start", 32'(cs), 32'h00000001);
        chk("t1_last", 32'(cl), 32'h00000008);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_ready", 32'(in_ready), 32'd1);

        // carry-in held across frame; inputs changed mid-frame must not matter
        @(posedge clk); #1 drive(1'b1, 4'hF, 4'h1, 1'b1, 1'b0);
        @(posedge clk); #1 drive(1'b0, 4'h0, 4'hA, 1'b0, 1'b0);
        collect(ca, cb, cc, cs, cl);
        chk("t2_cin", 32'(cc), 32'h0000000F);
        chk("t2_a", 32'(ca), 32'h0000000F);
        chk("t2_b", 32'(cb), 32'h00000001);
        @(negedge clk);
        chk("t2_cin_after", 32'(cin_out), 32'd0);

        // back-to-back: second set valid from bit 2, taken on bit 3
        @(posedge clk); #1 drive(1'b1, 4'h9, 4'hC, 1'b0, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 drive(1'b1, 4'h3, 4'h5, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_not_ready_bit2", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t3_ready_bit3", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t3_b2b", 32'({a_out, b_out, frame_start, done, bit_idx}), 32'b111100);
        repeat (5) @(posedge clk);

        // reset during bit 1
        #1 drive(1'b1, 4'h6, 4'h9, 1'b1, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_outs", 32'({a_out, b_out, cin_out, frame_start, frame_last, busy, bit_idx, done}), 32'd0);
        chk("t4_ready", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);

        // valid held 10 cycles: accepts at idle and at each last bit
        acc0 = m_acc; dacc0 = dut_acc;
        #1 drive(1'b1, 4'h7, 4'h2, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("t5_model_acc", 32'(m_acc - acc0), 32'd3);
        chk("t5_dut_acc", 32'(dut_acc - dacc0), 32'd3);
        repeat (6) @(posedge clk);

`ifdef SER_SUB_EN
        // subtract feed
        #1 drive(1'b1, 4'd5, 4'd3, 1'b0, 1'b1);
        @(posedge clk); #1 drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        collect(ca, cb, cc, cs, cl);
        chk("t6_a", 32'(ca), 32'h00000005);
        chk("t6_b", 32'(cb), 32'h0000000C);
        chk("t6_cin", 32'(cc), 32'h0000000F);
        repeat (3) @(posedge clk);
`endif

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
